// File: rtl/ifft8_serial.sv
// rtl/ifft8_serial.sv - sample-serial 8-point inverse FFT with one shared radix-2 butterfly; define IFFT8_ROUND_EN for rounding
module ifft8_serial #(
   parameter int DW   = 16,
   parameter int FRAC = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_real,
   input  logic signed [DW-1:0] in_imag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_real,
   output logic signed [DW-1:0] out_imag,
   output logic [2:0]           out_idx,
   output logic                 out_last,
   output logic                 busy
);

`ifdef IFFT8_ROUND_EN
   localparam logic signed [2*DW-1:0] MUL_BIAS = (2*DW)'(1 << (FRAC-1));
   localparam logic signed [DW+1:0]   SHR_BIAS = (DW+2)'(1);
`else
   localparam logic signed [2*DW-1:0] MUL_BIAS = '0;
   localparam logic signed [DW+1:0]   SHR_BIAS = '0;
`endif

   typedef enum logic [1:0] {S_LOAD, S_CALC, S_UNLOAD} state_t;

   state_t               state_q;
   logic [3:0]           cnt_q;
   logic [2:0]           idx_d;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic                 out_last_q;
   logic                 busy_q;
   logic [2:0]           out_idx_q;
   logic signed [DW-1:0] out_real_q;
   logic signed [DW-1:0] out_imag_q;

   logic signed [DW-1:0] buf_re_q [8];
   logic signed [DW-1:0] buf_im_q [8];

   logic [2:0]             bf_a;
   logic [2:0]             bf_b;
   logic [1:0]             tw_sel;
   logic signed [DW-1:0]   w_re, w_im;
   logic signed [DW-1:0]   a_re, a_im, b_re, b_im, t_re, t_im;
   logic signed [2*DW-1:0] prod_re, prod_im;
   logic signed [DW+1:0]   sum_re, sum_im, dif_re, dif_im;
   logic signed [DW-1:0]   a_re_d, a_im_d, b_re_d, b_im_d;

   assign idx_d = cnt_q[2:0] + 3'd1;

   // Butterfly addressing: cnt_q[3:2] is the stage (span 1,2,4), cnt_q[1:0] the butterfly within it
   always_comb begin
      bf_a   = 3'd0;
      tw_sel = 2'd0;
      case (cnt_q[3:2])
         2'd0: bf_a = {cnt_q[1:0], 1'b0};
         2'd1: begin
            bf_a   = {cnt_q[1], 1'b0, cnt_q[0]};
            tw_sel = {cnt_q[0], 1'b0};
         end
         default: begin
            bf_a   = {1'b0, cnt_q[1:0]};
            tw_sel = cnt_q[1:0];
         end
      endcase
      bf_b = bf_a | (3'b001 << cnt_q[3:2]);
   end

   // Conjugate twiddles W8^-m in Q8.8
   always_comb begin
      case (tw_sel)
         2'd0:    begin w_re = DW'(256);  w_im = DW'(0);   end
         2'd1:    begin w_re = DW'(181);  w_im = DW'(181); end
         2'd2:    begin w_re = DW'(0);    w_im = DW'(256); end
         default: begin w_re = DW'(-181); w_im = DW'(181); end
      endcase
   end

   // Shared butterfly: t = w*b (bypassed for W^0), a' = (a+t)/2, b' = (a-t)/2 with floor or round-half-up
   always_comb begin
      a_re    = buf_re_q[bf_a];
      a_im    = buf_im_q[bf_a];
      b_re    = buf_re_q[bf_b];
      b_im    = buf_im_q[bf_b];
      prod_re = (2*DW)'(w_re) * (2*DW)'(b_re) - (2*DW)'(w_im) * (2*DW)'(b_im) + MUL_BIAS;
      prod_im = (2*DW)'(w_re) * (2*DW)'(b_im) + (2*DW)'(w_im) * (2*DW)'(b_re) + MUL_BIAS;
      if (tw_sel == 2'd0) begin
         t_re = b_re;
         t_im = b_im;
      end else begin
         t_re = DW'(prod_re >>> FRAC);
         t_im = DW'(prod_im >>> FRAC);
      end
      sum_re = (DW+2)'(a_re) + (DW+2)'(t_re) + SHR_BIAS;
      sum_im = (DW+2)'(a_im) + (DW+2)'(t_im) + SHR_BIAS;
      dif_re = (DW+2)'(a_re) - (DW+2)'(t_re) + SHR_BIAS;
      dif_im = (DW+2)'(a_im) - (DW+2)'(t_im) + SHR_BIAS;
      a_re_d = DW'(sum_re >>> 1);
      a_im_d = DW'(sum_im >>> 1);
      b_re_d = DW'(dif_re >>> 1);
      b_im_d = DW'(dif_im >>> 1);
   end

   // Sample buffer: bins land bit-reversed on load, butterflies write back in place
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD && in_valid) begin
         buf_re_q[{cnt_q[0], cnt_q[1], cnt_q[2]}] <= in_real;
         buf_im_q[{cnt_q[0], cnt_q[1], cnt_q[2]}] <= in_imag;
      end else if (state_q == S_CALC) begin
         buf_re_q[bf_a] <= a_re_d;
         buf_im_q[bf_a] <= a_im_d;
         buf_re_q[bf_b] <= b_re_d;
         buf_im_q[bf_b] <= b_im_d;
      end
   end

   // Frame sequencer LOAD -> CALC -> UNLOAD with registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_LOAD;
         cnt_q       <= 4'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_real_q  <= '0;
         out_imag_q  <= '0;
         out_idx_q   <= 3'd0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (in_valid && in_ready_q) begin
                  if (cnt_q == 4'd7) begin
                     state_q    <= S_CALC;
                     cnt_q      <= 4'd0;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            S_CALC: begin
               if (cnt_q == 4'd11) begin
                  // buffer[0] was finished by butterfly 8, so it is safe to present now
                  state_q     <= S_UNLOAD;
                  cnt_q       <= 4'd0;
                  out_valid_q <= 1'b1;
                  out_real_q  <= buf_re_q[0];
                  out_imag_q  <= buf_im_q[0];
                  out_idx_q   <= 3'd0;
                  out_last_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_UNLOAD: begin
               if (out_ready) begin
                  if (cnt_q[2:0] == 3'd7) begin
                     state_q     <= S_LOAD;
                     cnt_q       <= 4'd0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     in_ready_q  <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     cnt_q      <= {1'b0, idx_d};
                     out_real_q <= buf_re_q[idx_d];
                     out_imag_q <= buf_im_q[idx_d];
                     out_idx_q  <= idx_d;
                     out_last_q <= (idx_d == 3'd7);
                  end
               end
            end
            default: begin
               state_q <= S_LOAD;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_real  = out_real_q;
   assign out_imag  = out_imag_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ifft8_serial.sv
// tb/tb_ifft8_serial.sv - self-checking bench for ifft8_serial against an in-bench IFFT model
module tb_ifft8_serial;
   localparam int DW = 16;
`ifdef IFFT8_ROUND_EN
   localparam int MB = 128;
   localparam int SB = 1;
`else
   localparam int MB = 0;
   localparam int SB = 0;
`endif
   localparam real PI = 3.14159265358979;

   typedef struct {
      int r;
      int i;
      int idx;
   } samp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] in_real = '0;
   logic signed [DW-1:0] in_imag = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic signed [DW-1:0] out_real;
   logic signed [DW-1:0] out_imag;
   logic [2:0]           out_idx;
   logic                 out_last;
   logic                 busy;

   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   int    acc_edge = 0;
   bit    lat_pending = 1'b0;
   bit    chk_ir = 1'b0;
   bit    prev_stall = 1'b0;
   int    rdy_mode = 0;
   samp_t exp_q[$];
   int    fr[8];
   int    fi[8];
   int    got_r[8];
   int    got_i[8];
   logic signed [DW-1:0] prev_r, prev_i;
   logic [2:0]           prev_idx;

   always #5 clk = ~clk;

   ifft8_serial #(.DW(DW), .FRAC(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_real  (out_real),
      .out_imag  (out_imag),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   task automatic chk(input string nm, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic chk_tol(input string nm, input int act, input real req, input int tol);
      tests++;
      if ((act - req) > tol || (req - act) > tol) begin
         fails++;
         $display("FAIL %s: got %0d, required %f +/- %0d", nm, act, req, tol);
      end
   endtask

   function automatic int sx16(input int v);
      return (v <<< 16) >>> 16;
   endfunction

   function automatic int bitrev3(input int k);
      return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
   endfunction

   // Textbook iterative radix-2 DIT with per-stage halving and conjugate twiddles
   function automatic void model(input int xr[8], input int xi[8], output int yr[8], output int yi[8]);
      int wr[4];
      int wi[4];
      int h, m, ia, ib, tr, ti, sr, si;
      wr = '{256, 181, 0, -181};
      wi = '{0, 181, 256, 181};
      for (int k = 0; k < 8; k++) begin
         yr[bitrev3(k)] = xr[k];
         yi[bitrev3(k)] = xi[k];
      end
      for (int s = 0; s < 3; s++) begin
         h = 1 << s;
         for (int g = 0; g < 8; g += 2 * h) begin
            for (int j = 0; j < h; j++) begin
               m  = j * (4 / h);
               ia = g + j;
               ib = ia + h;
               if (m == 0) begin
                  tr = yr[ib];
                  ti = yi[ib];
               end else begin
                  tr = sx16((wr[m] * yr[ib] - wi[m] * yi[ib] + MB) >>> 8);
                  ti = sx16((wr[m] * yi[ib] + wi[m] * yr[ib] + MB) >>> 8);
               end
               sr = yr[ia];
               si = yi[ia];
               yr[ia] = sx16((sr + tr + SB) >>> 1);
               yi[ia] = sx16((si + ti + SB) >>> 1);
               yr[ib] = sx16((sr - tr + SB) >>> 1);
               yi[ib] = sx16((si - ti + SB) >>> 1);
            end
         end
      end
   endfunction

   task automatic fill(input int kind);
      for (int k = 0; k < 8; k++) begin
         case (kind)
            0: begin fr[k] = (k == 0) ? 256 : 0;  fi[k] = 0; end
            1: begin fr[k] = 256;                 fi[k] = 0; end
            2: begin fr[k] = (k == 1) ? 2048 : 0; fi[k] = 0; end
            default: begin
               fr[k] = int'($urandom_range(2046)) - 1023;
               fi[k] = int'($urandom_range(2046)) - 1023;
            end
         endcase
      end
   endtask

   // Queues the expected samples, pins the model against a real-valued IDFT, then drives 8 bins
   task automatic send_frame(input bit keep_valid);
      int    yr[8];
      int    yi[8];
      int    n;
      real   rr, ri, ang;
      samp_t s;
      model(fr, fi, yr, yi);
      for (int t = 0; t < 8; t++) begin
         rr = 0.0;
         ri = 0.0;
         for (int k = 0; k < 8; k++) begin
            ang = 2.0 * PI * real'(k * t) / 8.0;
            rr += real'(fr[k]) * $cos(ang) - real'(fi[k]) * $sin(ang);
            ri += real'(fr[k]) * $sin(ang) + real'(fi[k]) * $cos(ang);
         end
         chk_tol("model_vs_idft_re", yr[t], rr / 8.0, 3);
         chk_tol("model_vs_idft_im", yi[t], ri / 8.0, 3);
         s.r = yr[t];
         s.i = yi[t];
         s.idx = t;
         exp_q.push_back(s);
      end
      for (int k = 0; k < 8; k++) begin
         in_real  = DW'(fr[k]);
         in_imag  = DW'(fi[k]);
         in_valid = 1'b1;
         n = 0;
         @(negedge clk);
         while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
         end
         if (!in_ready) chk("in_ready_timeout", in_ready, 1);
         if (k == 7) begin
            acc_edge    = cyc + 1;
            lat_pending = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!keep_valid) in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("drain_timeout_pending", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_got();
      for (int k = 0; k < 8; k++) begin
         got_r[k] = -99999;
         got_i[k] = -99999;
      end
   endtask

   // Cycle counter: value at a negedge equals the number of rising edges so far
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Downstream ready: always, 1-0-0-1 pattern, or random
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
               ph++;
            end
            default: out_ready = 1'($urandom_range(1));
         endcase
      end
   end

   // Output compare against the model queue on every meaningful cycle
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         chk("reset_out_valid", out_valid, 0);
         chk("reset_in_ready", in_ready, 1);
         chk("reset_busy", busy, 0);
         chk("reset_out_real", out_real, 0);
         chk("reset_out_imag", out_imag, 0);
         chk("reset_out_idx", out_idx, 0);
         chk("reset_out_last", out_last, 0);
         prev_stall = 1'b0;
         chk_ir = 1'b0;
      end else begin
         if (chk_ir) begin
            chk("in_ready_after_last", in_ready, 1);
            chk("out_valid_after_last", out_valid, 0);
            chk_ir = 1'b0;
         end
         if (out_valid) begin
            if (lat_pending) begin
               chk("first_valid_latency", cyc - acc_edge, 12);
               lat_pending = 1'b0;
            end
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got sample idx %0d, required no output", out_idx);
            end else begin
               chk("out_real", out_real, exp_q[0].r);
               chk("out_imag", out_imag, exp_q[0].i);
               chk("out_idx", out_idx, exp_q[0].idx);
               chk("out_last", out_last, (exp_q[0].idx == 7) ? 1 : 0);
               chk("in_ready_in_unload", in_ready, 0);
               chk("busy_in_unload", busy, 1);
            end
            if (prev_stall) begin
               chk("stall_real_stable", out_real, prev_r);
               chk("stall_imag_stable", out_imag, prev_i);
               chk("stall_idx_stable", out_idx, prev_idx);
            end
            if (out_ready) begin
               if (exp_q.size() != 0) begin
                  got_r[exp_q[0].idx] = int'(out_real);
                  got_i[exp_q[0].idx] = int'(out_imag);
                  if (exp_q[0].idx == 7) chk_ir = 1'b1;
                  void'(exp_q.pop_front());
               end
               prev_stall = 1'b0;
            end else begin
               prev_stall = 1'b1;
               prev_r     = out_real;
               prev_i     = out_imag;
               prev_idx   = out_idx;
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Impulse: all outputs (32,0)
      rdy_mode = 0;
      clear_got();
      fill(0);
      send_frame(1'b0);
      wait_idle();
      for (int n = 0; n < 8; n++) begin
         chk("impulse_re", got_r[n], 32);
         chk("impulse_im", got_i[n], 0);
      end

      // Flat spectrum: (256,0) at n=0, zero elsewhere
      clear_got();
      fill(1);
      send_frame(1'b0);
      wait_idle();
      chk("flat_re0", got_r[0], 256);
      chk("flat_im0", got_i[0], 0);
      for (int n = 1; n < 8; n++) begin
         chk("flat_re", got_r[n], 0);
         chk("flat_im", got_i[n], 0);
      end

      // Single tone: 256*e^{+j2pi n/8}
      clear_got();
      fill(2);
      send_frame(1'b0);
      wait_idle();
      chk_tol("tone_re0", got_r[0], 256.0, 3);
      chk_tol("tone_im0", got_i[0], 0.0, 3);
      chk_tol("tone_re1", got_r[1], 181.0, 3);
      chk_tol("tone_im1", got_i[1], 181.0, 3);
      chk_tol("tone_re2", got_r[2], 0.0, 3);
      chk_tol("tone_im2", got_i[2], 256.0, 3);
      chk_tol("tone_re4", got_r[4], -256.0, 3);
      chk_tol("tone_im4", got_i[4], 0.0, 3);
      chk_tol("tone_re6", got_r[6], 0.0, 3);
      chk_tol("tone_im6", got_i[6], -256.0, 3);

      // Backpressure 1,0,0,1 with junk in_valid pulses during CALC
      rdy_mode = 1;
      fill(3);
      send_frame(1'b0);
      for (int c = 0; c < 8; c++) begin
         in_valid = 1'($urandom_range(1));
         in_real  = DW'($urandom);
         in_imag  = DW'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_idle();
      fill(3);
      send_frame(1'b0);
      wait_idle();

      // Reset in the middle of CALC, then a clean impulse frame
      rdy_mode = 0;
      fill(0);
      send_frame(1'b0);
      repeat (5) @(posedge clk);
      #2;
      chk("busy_before_reset", busy, 1);
      exp_q.delete();
      lat_pending = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_reset_in_ready", in_ready, 1);
      chk("async_reset_busy", busy, 0);
      chk("async_reset_out_valid", out_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_got();
      fill(0);
      send_frame(1'b0);
      wait_idle();
      for (int n = 0; n < 8; n++) begin
         chk("post_reset_re", got_r[n], 32);
         chk("post_reset_im", got_i[n], 0);
      end

      // Back-to-back: flat then impulse with in_valid held high
      fill(1);
      send_frame(1'b1);
      clear_got();
      fill(0);
      send_frame(1'b0);
      wait_idle();
      for (int n = 0; n < 8; n++) begin
         chk("b2b_impulse_re", got_r[n], 32);
         chk("b2b_impulse_im", got_i[n], 0);
      end

      // Random frames with random downstream ready
      rdy_mode = 2;
      for (int f = 0; f < 20; f++) begin
         fill(3);
         send_frame(f[0]);
      end
      in_valid = 1'b0;
      wait_idle();
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ifft8_serial.md
Name: ifft8_serial

Overview:
- Sample-serial 8-point inverse FFT: the inverse-direction companion to the team's combinational 8-point forward DFT datapath.
- Accepts 8 complex Q8.8 frequency-domain bins over a valid/ready stream and computes radix-2 DIT with one time-shared butterfly and conjugate twiddles.
- Applies the 1/N normalisation as a 1-bit shift per stage.
- Streams the 8 complex Q8.8 time-domain samples out over a valid/ready stream.

Parameters:
- DW, 16, sample component width (Q8.8 signed); twiddle constants assume DW=16.
- FRAC, 8, fractional bits; complex-multiply product slice is [FRAC+DW-1:FRAC].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input bin valid
- in_ready  out  1  block can accept a bin
- in_real  in  DW  bin real part, signed Q8.8
- in_imag  in  DW  bin imag part, signed Q8.8
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts sample
- out_real  out  DW  sample real part, signed Q8.8
- out_imag  out  DW  sample imag part, signed Q8.8
- out_idx  out  3  time index n of current output sample
- out_last  out  1  high with sample n=7
- busy  out  1  high in CALC or UNLOAD

Behaviour:
- Reset (async, rst_n=0): state=LOAD; counters=0; in_ready=1; out_valid=0; out_real=out_imag=0; out_idx=0; out_last=0; busy=0. Buffer contents are don't-care.
- Reset mid-frame, in any state: the partial frame is discarded and no further output is produced for it.
- LOAD:
  - in_ready=1. Each edge with in_valid&in_ready writes bin k (k = 0..7 in arrival order) to buffer[bitrev3(k)]; k increments.
  - On acceptance of k=7, go to CALC.
- CALC:
  - in_ready=0, busy=1. Exactly 12 cycles, one butterfly per cycle: stages s=0,1,2; 4 butterflies per stage; span 1,2,4.
  - Butterfly on pair (a,b) with twiddle w=W8^(-m): t = w*b; a' = (a+t)>>>1; b' = (a-t)>>>1.
  - Sums are computed at DW+1 bits before the arithmetic shift, so no overflow.
  - Complex multiply: four DWxDW signed products at 2*DW bits; re = ac - bd; im = ad + bc; slice [23:8], truncate.
  - Twiddles (re,im) in Q8.8: W^0 = (256,0); W^-1 = (181,181); W^-2 = (0,256); W^-3 = (-181,181).
  - The W^0 multiply is bypassed (t=b).
  - The result is written back in place on the same edge.
  - After the 12th butterfly edge, go to UNLOAD.
- UNLOAD:
  - out_valid=1; out_real/out_imag = buffer[n] in natural order, n = 0..7; out_idx=n.
  - Outputs are held stable while out_ready=0.
  - Each edge with out_valid&out_ready advances n. out_last=1 when n=7.
  - After the handshake of n=7: out_valid=0, state=LOAD, in_ready=1 on the next cycle.
- Latency: first out_valid is asserted in the cycle after the 12th clock edge following acceptance of bin 7. Throughput is one frame per 8+12+8 cycles minimum.
- No input/output overlap: in_ready=0 throughout CALC and UNLOAD. in_valid during those states is ignored with no side effects.
- Overall scaling is 1/8: for Q8.8 inputs, output = IDFT(X) = (1/8)·sum X[k]e^{+j2πkn/8}.
- The only precision loss is truncation (floor) at each stage shift and at the multiply slice.

Optional Feature:
- IFFT8_ROUND_EN defined: each stage shift becomes (v+1)>>>1 (round half up), and the multiply slice adds 1<<(FRAC-1) before slicing. This reduces worst-case error to ±1 LSB per output.
- IFFT8_ROUND_EN undefined: pure truncation as in Behaviour. Error bound is ±3 LSB per output component.
- Timing and handshakes are identical in both builds.

Test Plan:
- Impulse: X[0]=256, X[1..7]=0 (imag all 0), out_ready=1 -> all 8 outputs (32,0). First out_valid exactly 12 edges after bin 7 accepted; out_last only on n=7.
- Flat spectrum: X[k]=(256,0) for all k -> out n=0 = (256,0), n=1..7 = (0,0), exact in both builds.
- Single tone: X[1]=(2048,0), rest 0 -> out[n] ≈ 256·e^{+j2πn/8}: n=0 (256,0), n=1 (181,181), n=2 (0,256), n=4 (-256,0), n=6 (0,-256). Tolerance ±3 LSB truncating, ±1 rounding.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly -> out_real/out_imag/out_idx stable while stalled; exactly 8 handshakes; in_ready stays 0 until after the n=7 handshake. in_valid pulses during CALC do not corrupt the next frame.
- Reset mid-CALC: assert rst_n=0 at butterfly 5 -> outputs go immediately to reset values. A new impulse frame then yields 8×(32,0) with no stale samples.
- Back-to-back frames: a flat frame then an impulse frame, in_valid held high -> in_ready reasserts one cycle after n=7 of frame 1; frame 2 outputs are all (32,0).
